// File: rtl/rv_ctrl_pipe.sv
// rv_ctrl_pipe: pipelined control unit for the five-stage RV32I core.
// Decodes the opcode in D and carries the control word through the E, M and W
// registers so each stage sees controls aligned with its datapath. It honours
// hazard-unit flushes and D-stage bubbles, and flags and counts illegal opcodes.
//
// Build option: define RV_CTRL_UJ_EN to decode JAL, JALR, LUI and AUIPC.
// Without it those four opcodes are treated as illegal.
//
// Flow control: there is no ready/backpressure. InstrValidD=1 means D holds a
// real instruction that is accepted into E on this rising edge, unless FlushE
// is high. InstrValidD=0 or FlushE=1 loads a bubble (all-zero word) into E.
// M and W always advance, one instruction per cycle.
module rv_ctrl_pipe #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 InstrValidD,
    input  logic [6:0]           OpD,
    input  logic                 FlushE,
    output logic [2:0]           ImmSrcD,
    output logic                 RegWriteE,
    output logic                 ALUSrcE,
    output logic                 ALUSrcAE,
    output logic                 MemWriteE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           ALUOpE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic                 IllegalE,
    output logic [ILL_CNT_W-1:0] IllCnt
);

    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic       aluSrcA;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic [1:0] resultSrc;
        logic [1:0] aluOp;
    } ctrlWordT;

    localparam logic [ILL_CNT_W-1:0] CNT_ONE = ILL_CNT_W'(1);
    localparam logic [ILL_CNT_W-1:0] CNT_MAX = '1;

    ctrlWordT   decWord;
    logic [2:0] decImm;
    logic       decLegal;
    logic       illegalD;

    ctrlWordT   eWord;
    logic       mRegWrite;
    logic       mMemWrite;
    logic [1:0] mResultSrc;
    logic       wRegWrite;
    logic [1:0] wResultSrc;

    // Opcode decode: unknown opcodes leave the word all-zero and clear decLegal.
    always_comb begin
        decWord  = '0;
        decImm   = 3'b000;
        decLegal = 1'b1;
        case (OpD)
            7'b0110011: begin
                decWord.regWrite = 1'b1;
                decWord.aluOp    = 2'b10;
            end
            7'b0010011: begin
                decWord.regWrite = 1'b1;
                decWord.aluSrc   = 1'b1;
                decWord.aluOp    = 2'b10;
            end
            7'b0000011: begin
                decWord.regWrite  = 1'b1;
                decWord.aluSrc    = 1'b1;
                decWord.resultSrc = 2'b01;
            end
            7'b0100011: begin
                decImm           = 3'b001;
                decWord.aluSrc   = 1'b1;
                decWord.memWrite = 1'b1;
            end
            7'b1100011: begin
                decImm         = 3'b010;
                decWord.branch = 1'b1;
                decWord.aluOp  = 2'b01;
            end
`ifdef RV_CTRL_UJ_EN
            7'b1101111: begin
                decImm            = 3'b011;
                decWord.regWrite  = 1'b1;
                decWord.jump      = 1'b1;
                decWord.resultSrc = 2'b10;
            end
            7'b1100111: begin
                decWord.regWrite  = 1'b1;
                decWord.aluSrc    = 1'b1;
                decWord.jump      = 1'b1;
                decWord.resultSrc = 2'b10;
            end
            7'b0110111: begin
                decImm           = 3'b100;
                decWord.regWrite = 1'b1;
                decWord.aluSrc   = 1'b1;
                decWord.aluOp    = 2'b11;
            end
            7'b0010111: begin
                decImm           = 3'b100;
                decWord.regWrite = 1'b1;
                decWord.aluSrc   = 1'b1;
                decWord.aluSrcA  = 1'b1;
            end
`endif
            default: begin
                decLegal = 1'b0;
            end
        endcase
    end

    // The extender only sees a format for a real, legal instruction.
    assign ImmSrcD  = InstrValidD ? decImm : 3'b000;
    assign illegalD = InstrValidD & ~decLegal;

    // E register: flush beats bubble beats a real decoded word.
    always_ff @(posedge clk) begin
        if (rst) begin
            eWord    <= '0;
            IllegalE <= 1'b0;
        end else if (FlushE) begin
            eWord    <= '0;
            IllegalE <= 1'b0;
        end else if (!InstrValidD) begin
            eWord    <= '0;
            IllegalE <= 1'b0;
        end else begin
            eWord    <= decWord;
            IllegalE <= illegalD;
        end
    end

    // M and W never stall or flush; bubbles simply propagate.
    always_ff @(posedge clk) begin
        if (rst) begin
            mRegWrite  <= 1'b0;
            mMemWrite  <= 1'b0;
            mResultSrc <= 2'b00;
            wRegWrite  <= 1'b0;
            wResultSrc <= 2'b00;
        end else begin
            mRegWrite  <= eWord.regWrite;
            mMemWrite  <= eWord.memWrite;
            mResultSrc <= eWord.resultSrc;
            wRegWrite  <= mRegWrite;
            wResultSrc <= mResultSrc;
        end
    end

    // Saturating count of illegal instructions that reached E.
    always_ff @(posedge clk) begin
        if (rst) begin
            IllCnt <= '0;
        end else if (IllegalE && (IllCnt != CNT_MAX)) begin
            IllCnt <= IllCnt + CNT_ONE;
        end
    end

    assign RegWriteE  = eWord.regWrite;
    assign ALUSrcE    = eWord.aluSrc;
    assign ALUSrcAE   = eWord.aluSrcA;
    assign MemWriteE  = eWord.memWrite;
    assign BranchE    = eWord.branch;
    assign JumpE      = eWord.jump;
    assign ResultSrcE = eWord.resultSrc;
    assign ALUOpE     = eWord.aluOp;
    assign RegWriteM  = mRegWrite;
    assign MemWriteM  = mMemWrite;
    assign ResultSrcM = mResultSrc;
    assign RegWriteW  = wRegWrite;
    assign ResultSrcW = wResultSrc;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// tb_rv_ctrl_pipe: self-checking bench for rv_ctrl_pipe.
// Reference model: opcode -> {ImmSrc, control word} lookup table plus a queue
// holding the words that entered E over the last three cycles (newest = E).
module tb_rv_ctrl_pipe;

    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          InstrValidD = 1'b0;
    logic [6:0]    OpD = 7'd0;
    logic          FlushE = 1'b0;
    logic [2:0]    ImmSrcD;
    logic          RegWriteE, ALUSrcE, ALUSrcAE, MemWriteE, BranchE, JumpE;
    logic [1:0]    ResultSrcE, ALUOpE;
    logic          RegWriteM, MemWriteM;
    logic [1:0]    ResultSrcM;
    logic          RegWriteW;
    logic [1:0]    ResultSrcW;
    logic          IllegalE;
    logic [CW-1:0] IllCnt;

    rv_ctrl_pipe #(.ILL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .InstrValidD(InstrValidD), .OpD(OpD), .FlushE(FlushE),
        .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .ALUOpE(ALUOpE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .IllegalE(IllegalE), .IllCnt(IllCnt)
    );

    int nChecks = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word bit order: [9]RegWrite [8]ALUSrc [7]ALUSrcA [6]MemWrite [5]Branch
    // [4]Jump [3:2]ResultSrc [1:0]ALUOp
    typedef struct packed {
        logic [9:0] w;
        logic       ill;
    } stageT;

    logic [12:0] refTab [bit [6:0]];   // {ImmSrc, word}
    stageT       pipeQ[$];
    int          refCnt = 0;
    logic [2:0]  lastImm;

    function automatic logic [9:0] actE();
        return {RegWriteE, ALUSrcE, ALUSrcAE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUOpE};
    endfunction

    // Drive one D-stage cycle: check ImmSrcD before the edge, then every
    // registered output against the model after it.
    task automatic step(input logic v, input logic [6:0] op, input logic fl, input logic r);
        logic   known;
        stageT  nw;
        stageT  z;
        InstrValidD = v;
        OpD = op;
        FlushE = fl;
        rst = r;
        known = refTab.exists(op);
        #1;
        lastImm = ImmSrcD;
        check("ImmSrcD", ImmSrcD, (v && known) ? refTab[op][12:10] : 3'b000);
        @(posedge clk);
        #1;
        z = '0;
        if (r) begin
            pipeQ = '{z, z, z};
            refCnt = 0;
        end else begin
            if (pipeQ[2].ill && refCnt < CNT_MAX) refCnt++;
            nw = '0;
            if (!fl && v) begin
                nw.w   = known ? refTab[op][9:0] : 10'd0;
                nw.ill = !known;
            end
            pipeQ.push_back(nw);
            void'(pipeQ.pop_front());
        end
        check("E_word", actE(), pipeQ[2].w);
        check("IllegalE", IllegalE, pipeQ[2].ill);
        check("M_word", {RegWriteM, MemWriteM, ResultSrcM},
              {pipeQ[1].w[9], pipeQ[1].w[6], pipeQ[1].w[3:2]});
        check("W_word", {RegWriteW, ResultSrcW}, {pipeQ[0].w[9], pipeQ[0].w[3:2]});
        check("IllCnt", IllCnt, refCnt);
    endtask

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic       fl;
        logic [2:0] imm;
        logic [9:0] e;
        logic       ill;
    } vecT;

    vecT        vecs[$];
    logic [6:0] opList [10] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JLR, OP_LUI, OP_AUI, OP_BAD};

    initial begin
        stageT z;
        z = '0;
        pipeQ = '{z, z, z};

        refTab[OP_R]  = {3'b000, 10'b1000000010};
        refTab[OP_I]  = {3'b000, 10'b1100000010};
        refTab[OP_LD] = {3'b000, 10'b1100000100};
        refTab[OP_ST] = {3'b001, 10'b0101000000};
        refTab[OP_BR] = {3'b010, 10'b0000100001};
`ifdef RV_CTRL_UJ_EN
        refTab[OP_JAL] = {3'b011, 10'b1000011000};
        refTab[OP_JLR] = {3'b000, 10'b1100011000};
        refTab[OP_LUI] = {3'b100, 10'b1100000011};
        refTab[OP_AUI] = {3'b100, 10'b1110000000};
`endif

        // Single-cycle vectors: {valid, op, flush, ImmSrcD, E word, IllegalE}
        vecs.push_back({1'b1, OP_R,  1'b0, 3'b000, 10'b1000000010, 1'b0});
        vecs.push_back({1'b1, OP_I,  1'b0, 3'b000, 10'b1100000010, 1'b0});
        vecs.push_back({1'b1, OP_LD, 1'b0, 3'b000, 10'b1100000100, 1'b0});
        vecs.push_back({1'b1, OP_ST, 1'b0, 3'b001, 10'b0101000000, 1'b0});
        vecs.push_back({1'b1, OP_BR, 1'b0, 3'b010, 10'b0000100001, 1'b0});
        vecs.push_back({1'b0, OP_ST, 1'b0, 3'b000, 10'b0000000000, 1'b0});
        vecs.push_back({1'b1, OP_BAD, 1'b0, 3'b000, 10'b0000000000, 1'b1});
        vecs.push_back({1'b0, OP_BAD, 1'b0, 3'b000, 10'b0000000000, 1'b0});
        vecs.push_back({1'b1, OP_BAD, 1'b1, 3'b000, 10'b0000000000, 1'b0});
        vecs.push_back({1'b1, OP_BR, 1'b1, 3'b010, 10'b0000000000, 1'b0});
`ifdef RV_CTRL_UJ_EN
        vecs.push_back({1'b1, OP_JAL, 1'b0, 3'b011, 10'b1000011000, 1'b0});
        vecs.push_back({1'b1, OP_JLR, 1'b0, 3'b000, 10'b1100011000, 1'b0});
        vecs.push_back({1'b1, OP_LUI, 1'b0, 3'b100, 10'b1100000011, 1'b0});
        vecs.push_back({1'b1, OP_AUI, 1'b0, 3'b100, 10'b1110000000, 1'b0});
`else
        vecs.push_back({1'b1, OP_JAL, 1'b0, 3'b000, 10'b0000000000, 1'b1});
        vecs.push_back({1'b1, OP_JLR, 1'b0, 3'b000, 10'b0000000000, 1'b1});
        vecs.push_back({1'b1, OP_LUI, 1'b0, 3'b000, 10'b0000000000, 1'b1});
        vecs.push_back({1'b1, OP_AUI, 1'b0, 3'b000, 10'b0000000000, 1'b1});
`endif

        // Reset: every registered output reads 0
        step(1'b0, 7'd0, 1'b0, 1'b1);
        step(1'b0, 7'd0, 1'b0, 1'b1);
        check("reset_all_zero",
              {actE(), RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW, IllegalE, IllCnt}, '0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].op, vecs[i].fl, 1'b0);
            check("vec_imm", lastImm, vecs[i].imm);
            check("vec_eword", actE(), vecs[i].e);
            check("vec_ill", IllegalE, vecs[i].ill);
        end

        // R-type latency to W
        step(1'b0, 7'd0, 1'b0, 1'b1);
        step(1'b1, OP_R, 1'b0, 1'b0);
        check("r_e", {RegWriteE, ALUOpE, ALUSrcE}, {1'b1, 2'b10, 1'b0});
        step(1'b0, 7'd0, 1'b0, 1'b0);
        step(1'b0, 7'd0, 1'b0, 1'b0);
        check("r_w", {RegWriteW, ResultSrcW}, {1'b1, 2'b00});

        // Load then store back-to-back
        step(1'b1, OP_LD, 1'b0, 1'b0);
        check("ld_imm", lastImm, 3'b000);
        step(1'b1, OP_ST, 1'b0, 1'b0);
        check("st_imm", lastImm, 3'b001);
        check("ld_m", ResultSrcM, 2'b01);
        step(1'b0, 7'd0, 1'b0, 1'b0);
        check("st_m", MemWriteM, 1'b1);

        // JAL, both builds
        step(1'b0, 7'd0, 1'b0, 1'b1);
        step(1'b1, OP_JAL, 1'b0, 1'b0);
`ifdef RV_CTRL_UJ_EN
        check("jal_imm", lastImm, 3'b011);
        check("jal_e", {JumpE, RegWriteE, ResultSrcE}, {1'b1, 1'b1, 2'b10});
        step(1'b0, 7'd0, 1'b0, 1'b0);
        step(1'b0, 7'd0, 1'b0, 1'b0);
        check("jal_w", ResultSrcW, 2'b10);
`else
        check("jal_ill", IllegalE, 1'b1);
        step(1'b0, 7'd0, 1'b0, 1'b0);
        check("jal_cnt", IllCnt, 1);
`endif

        // Illegal stream saturates the counter
        step(1'b0, 7'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 260; k++) begin
            step(1'b1, OP_BAD, 1'b0, 1'b0);
            check("sat_ill", IllegalE, 1'b1);
            check("sat_cnt", IllCnt, (k - 1 > CNT_MAX) ? CNT_MAX : k - 1);
        end
        step(1'b0, 7'd0, 1'b0, 1'b0);
        step(1'b0, 7'd0, 1'b0, 1'b0);
        check("sat_hold", IllCnt, CNT_MAX);

        // Flush against a branch, then a branch after the flush drops
        step(1'b1, OP_BR, 1'b1, 1'b0);
        check("flush_br", {BranchE, ALUOpE}, {1'b0, 2'b00});
        step(1'b1, OP_BR, 1'b0, 1'b0);
        check("br_after", {BranchE, ALUOpE}, {1'b1, 2'b01});

        // Reset in the middle of an R-type stream
        step(1'b1, OP_BAD, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, OP_R, 1'b0, 1'b0);
        step(1'b1, OP_R, 1'b0, 1'b1);
        check("midrst", {RegWriteE, RegWriteM, RegWriteW, IllCnt}, '0);

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : opList[$urandom_range(0, 9)];
            step($urandom_range(0, 9) < 8, op, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
